// File: rtl/if_fetch_queue_pkg.sv
// ============================================================================
// Module      : if_fetch_queue_pkg
// Description : Shared types and constants for the IF/ID fetch queue; carries
//               the sysconfig.v definitions used by this block (incl. INST_NOP).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef HISLEN
`define HISLEN 8
`endif
`ifndef TRAP_LEN
`define TRAP_LEN 8
`endif
`ifndef TRAP_BUS
`define TRAP_BUS `TRAP_LEN-1:0
`endif
`ifndef TRAP_INST_MISALIGN
`define TRAP_INST_MISALIGN 0
`endif
`ifndef TRAP_INST_ACCESS_FAULT
`define TRAP_INST_ACCESS_FAULT 1
`endif
`ifndef TRAP_INST_ILLEGAL
`define TRAP_INST_ILLEGAL 2
`endif
`ifndef TRAP_INST_PAGE_FAULT
`define TRAP_INST_PAGE_FAULT 3
`endif
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif

package if_fetch_queue_pkg;

  localparam logic [31:0] c_INST_NOP = `INST_NOP;

  typedef logic [`TRAP_BUS] trap_t;

  // Per-cycle queue operation, derived from the two handshakes.
  typedef enum logic [1:0] {
    IFQ_IDLE = 2'b00,
    IFQ_ENQ  = 2'b01,
    IFQ_DEQ  = 2'b10,
    IFQ_BOTH = 2'b11
  } ifq_op_e;

  function automatic ifq_op_e ifq_op(input logic enq_fire, input logic deq_fire);
    return ifq_op_e'({deq_fire, enq_fire});
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_queue_if.sv
// ============================================================================
// Module      : if_fetch_queue_if
// Description : Enqueue/dequeue handshake bundle between IFU, fetch queue, IDU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int HISLEN = `HISLEN
);
  import if_fetch_queue_pkg::*;

  logic                     enq_valid_i;
  logic                     enq_ready_o;
  logic [XLEN-1:0]          enq_addr_i;
  logic [XLEN-1:0]          enq_inst_i;
  trap_t                    enq_trap_i;
  logic                     enq_pdt_i;
  logic [HISLEN-1:0]        enq_hist_i;
  logic                     deq_valid_o;
  logic                     deq_ready_i;
  logic [XLEN-1:0]          deq_addr_o;
  logic [XLEN-1:0]          deq_inst_o;
  trap_t                    deq_trap_o;
  logic                     deq_pdt_o;
  logic [HISLEN-1:0]        deq_hist_o;
  logic                     flush_i;
  logic [$clog2(DEPTH):0]   count_o;

  // Pipeline side: IFU produces, IDU consumes, redirect logic flushes.
  modport master (
    output enq_valid_i, enq_addr_i, enq_inst_i, enq_trap_i, enq_pdt_i, enq_hist_i,
    output deq_ready_i, flush_i,
    input  enq_ready_o, deq_valid_o, deq_addr_o, deq_inst_o, deq_trap_o,
    input  deq_pdt_o, deq_hist_o, count_o
  );

  modport slave (
    input  enq_valid_i, enq_addr_i, enq_inst_i, enq_trap_i, enq_pdt_i, enq_hist_i,
    input  deq_ready_i, flush_i,
    output enq_ready_o, deq_valid_o, deq_addr_o, deq_inst_o, deq_trap_o,
    output deq_pdt_o, deq_hist_o, count_o
  );

endinterface

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module      : if_fetch_queue
// Description : First-word-fall-through FIFO between fetch and decode with
//               single-cycle flush. Optional counters under IFQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int HISLEN = `HISLEN
) (
  input  wire logic         clk,
  input  wire logic         rst,
  if_fetch_queue_if.slave   bus
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]       stat_full_cycles_o,
  output logic [31:0]       stat_flush_drops_o
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [XLEN-1:0]    r_addr_mem [DEPTH];
  logic [XLEN-1:0]    r_inst_mem [DEPTH];
  trap_t              r_trap_mem [DEPTH];
  logic               r_pdt_mem  [DEPTH];
  logic [HISLEN-1:0]  r_hist_mem [DEPTH];

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic    w_enq_ready;
  logic    w_deq_valid;
  logic    w_enq_fire;
  logic    w_deq_fire;
  ifq_op_e w_op;

  // Ready depends on occupancy only, so a full queue never accepts even
  // when the head is leaving in the same cycle.
  assign w_enq_ready = (r_count != c_FULL);
  assign w_deq_valid = (r_count != '0);
  assign w_enq_fire  = bus.enq_valid_i && w_enq_ready;
  assign w_deq_fire  = w_deq_valid && bus.deq_ready_i;
  assign w_op        = ifq_op(w_enq_fire, w_deq_fire);

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush_i && w_enq_fire) begin
      r_addr_mem[r_wr_ptr] <= bus.enq_addr_i;
      r_inst_mem[r_wr_ptr] <= bus.enq_inst_i;
      r_trap_mem[r_wr_ptr] <= bus.enq_trap_i;
      r_pdt_mem[r_wr_ptr]  <= bus.enq_pdt_i;
      r_hist_mem[r_wr_ptr] <= bus.enq_hist_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_deq_fire) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      unique case (w_op)
        IFQ_ENQ: r_count <= r_count + c_CNT_W'(1);
        IFQ_DEQ: r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty queue presents a NOP with no sideband so decode sees a clean bubble.
  assign bus.enq_ready_o = w_enq_ready;
  assign bus.deq_valid_o = w_deq_valid;
  assign bus.deq_addr_o  = w_deq_valid ? r_addr_mem[r_rd_ptr] : '0;
  assign bus.deq_inst_o  = w_deq_valid ? r_inst_mem[r_rd_ptr] : XLEN'(c_INST_NOP);
  assign bus.deq_trap_o  = w_deq_valid ? r_trap_mem[r_rd_ptr] : '0;
  assign bus.deq_pdt_o   = w_deq_valid ? r_pdt_mem[r_rd_ptr]  : 1'b0;
  assign bus.deq_hist_o  = w_deq_valid ? r_hist_mem[r_rd_ptr] : '0;
  assign bus.count_o     = r_count;

`ifdef IFQ_STATS_EN
  logic [31:0] r_full_cycles;
  logic [31:0] r_flush_drops;
  logic [32:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_flush_drops} + 33'(r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full_cycles <= '0;
      r_flush_drops <= '0;
    end else begin
      if (r_count == c_FULL && bus.enq_valid_i && r_full_cycles != '1)
        r_full_cycles <= r_full_cycles + 32'd1;
      if (bus.flush_i)
        r_flush_drops <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end
  end

  assign stat_full_cycles_o = r_full_cycles;
  assign stat_flush_drops_o = r_flush_drops;
`endif

  // The IFU must hold a stalled request steady; the queue does not latch it.
  a_enq_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.enq_valid_i && !w_enq_ready && !bus.flush_i) |=>
      (!bus.enq_valid_i || ($stable(bus.enq_addr_i) && $stable(bus.enq_inst_i))));

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    r_count <= c_FULL);

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Directed self-checking bench for if_fetch_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int XLEN   = 32;
  localparam int HISLEN = `HISLEN;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  if_fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .HISLEN(HISLEN)) ifc ();

`ifdef IFQ_STATS_EN
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_flush_drops;
`endif

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .HISLEN(HISLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
`ifdef IFQ_STATS_EN
    ,
    .stat_full_cycles_o (stat_full_cycles),
    .stat_flush_drops_o (stat_flush_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] addr, input logic [31:0] inst, input trap_t trap,
                     input logic pdt, input logic [HISLEN-1:0] hist);
    ifc.enq_valid_i = 1'b1;
    ifc.enq_addr_i  = addr;
    ifc.enq_inst_i  = inst;
    ifc.enq_trap_i  = trap;
    ifc.enq_pdt_i   = pdt;
    ifc.enq_hist_i  = hist;
    tick();
    ifc.enq_valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    ifc.deq_ready_i = 1'b1;
    repeat (n) tick();
    ifc.deq_ready_i = 1'b0;
  endtask

  initial begin
    trap_t pf;
    pf = '0;
    pf[`TRAP_INST_PAGE_FAULT] = 1'b1;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ifc.enq_valid_i = 1'b0;
    ifc.enq_addr_i  = '0;
    ifc.enq_inst_i  = '0;
    ifc.enq_trap_i  = '0;
    ifc.enq_pdt_i   = 1'b0;
    ifc.enq_hist_i  = '0;
    ifc.deq_ready_i = 1'b0;
    ifc.flush_i     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state: empty, ready, NOP head
    check_eq("rst_valid", 64'(ifc.deq_valid_o), 64'd0);
    check_eq("rst_ready", 64'(ifc.enq_ready_o), 64'd1);
    check_eq("rst_count", 64'(ifc.count_o), 64'd0);
    check_eq("rst_addr",  64'(ifc.deq_addr_o), 64'd0);
    check_eq("rst_inst",  64'(ifc.deq_inst_o), 64'h13);
    check_eq("rst_trap",  64'(ifc.deq_trap_o), 64'd0);
    check_eq("rst_pdt",   64'(ifc.deq_pdt_o), 64'd0);
    check_eq("rst_hist",  64'(ifc.deq_hist_o), 64'd0);

    // Single enqueue visible one cycle later
    enq(32'h8000_0000, 32'h0010_0093, '0, 1'b1, HISLEN'(8'h5A));
    check_eq("one_valid", 64'(ifc.deq_valid_o), 64'd1);
    check_eq("one_addr",  64'(ifc.deq_addr_o), 64'h8000_0000);
    check_eq("one_inst",  64'(ifc.deq_inst_o), 64'h0010_0093);
    check_eq("one_pdt",   64'(ifc.deq_pdt_o), 64'd1);
    check_eq("one_hist",  64'(ifc.deq_hist_o), 64'h5A);
    check_eq("one_count", 64'(ifc.count_o), 64'd1);

    // Fill to DEPTH, hold off a fifth request
    for (int i = 1; i < 4; i++)
      enq(32'h8000_0000 + 32'(4*i), 32'h0010_0093 + 32'(i), '0, 1'b0, '0);
    check_eq("full_count", 64'(ifc.count_o), 64'd4);
    check_eq("full_ready", 64'(ifc.enq_ready_o), 64'd0);
    ifc.enq_valid_i = 1'b1;
    ifc.enq_addr_i  = 32'h8000_0010;
    ifc.enq_inst_i  = 32'hDEAD_0013;
    repeat (2) tick();
    ifc.enq_valid_i = 1'b0;
    check_eq("held_count", 64'(ifc.count_o), 64'd4);
    check_eq("held_head",  64'(ifc.deq_addr_o), 64'h8000_0000);
`ifdef IFQ_STATS_EN
    check_eq("stat_full", 64'(stat_full_cycles), 64'd2);
`endif
    ifc.deq_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_addr", 64'(ifc.deq_addr_o), 64'h8000_0000 + 64'(4*i));
      check_eq("drain_inst", 64'(ifc.deq_inst_o), 64'h0010_0093 + 64'(i));
      tick();
    end
    ifc.deq_ready_i = 1'b0;
    check_eq("empty_count", 64'(ifc.count_o), 64'd0);
    check_eq("empty_valid", 64'(ifc.deq_valid_o), 64'd0);
    check_eq("empty_inst",  64'(ifc.deq_inst_o), 64'h13);

    // Streaming at count 1 across pointer wrap
    enq(32'h9000_0000, 32'h0000_0100, '0, 1'b0, '0);
    ifc.deq_ready_i = 1'b1;
    ifc.enq_valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_eq("stream_head",  64'(ifc.deq_addr_o), 64'h9000_0000 + 64'(4*k));
      check_eq("stream_count", 64'(ifc.count_o), 64'd1);
      ifc.enq_addr_i = 32'h9000_0000 + 32'(4*(k+1));
      ifc.enq_inst_i = 32'h0000_0100 + 32'(k+1);
      tick();
    end
    ifc.enq_valid_i = 1'b0;
    ifc.deq_ready_i = 1'b0;
    check_eq("stream_end_head",  64'(ifc.deq_addr_o), 64'h9000_0028);
    check_eq("stream_end_inst",  64'(ifc.deq_inst_o), 64'h0000_010A);
    check_eq("stream_end_count", 64'(ifc.count_o), 64'd1);
    drain(1);
    check_eq("stream_drained", 64'(ifc.count_o), 64'd0);

    // Flush wins over simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++)
      enq(32'hA000_0000 + 32'(4*i), 32'h0000_0200 + 32'(i), '0, 1'b0, '0);
    check_eq("pre_flush_count", 64'(ifc.count_o), 64'd3);
    ifc.enq_valid_i = 1'b1;
    ifc.enq_addr_i  = 32'hA000_000C;
    ifc.deq_ready_i = 1'b1;
    ifc.flush_i     = 1'b1;
    tick();
    ifc.enq_valid_i = 1'b0;
    ifc.deq_ready_i = 1'b0;
    ifc.flush_i     = 1'b0;
    check_eq("flush_count", 64'(ifc.count_o), 64'd0);
    check_eq("flush_valid", 64'(ifc.deq_valid_o), 64'd0);
    check_eq("flush_inst",  64'(ifc.deq_inst_o), 64'h13);
`ifdef IFQ_STATS_EN
    check_eq("stat_drops", 64'(stat_flush_drops), 64'd3);
`endif
    enq(32'hB000_0000, 32'h0000_0300, '0, 1'b0, '0);
    check_eq("post_flush_head",  64'(ifc.deq_addr_o), 64'hB000_0000);
    check_eq("post_flush_count", 64'(ifc.count_o), 64'd1);
    drain(1);

    // Trap entry travels with its own PC only
    enq(32'hC000_0FFC, 32'h0000_0400, '0, 1'b0, '0);
    enq(32'hC000_1000, 32'h0000_0401, pf, 1'b0, '0);
    enq(32'hC000_1004, 32'h0000_0402, '0, 1'b0, '0);
    check_eq("trap0_addr", 64'(ifc.deq_addr_o), 64'hC000_0FFC);
    check_eq("trap0_trap", 64'(ifc.deq_trap_o), 64'd0);
    drain(1);
    check_eq("trap1_addr", 64'(ifc.deq_addr_o), 64'hC000_1000);
    check_eq("trap1_trap", 64'(ifc.deq_trap_o), 64'(pf));
    drain(1);
    check_eq("trap2_addr", 64'(ifc.deq_addr_o), 64'hC000_1004);
    check_eq("trap2_trap", 64'(ifc.deq_trap_o), 64'd0);
    drain(1);

    // Reset with entries pending
    enq(32'hD000_0000, 32'h0000_0500, '0, 1'b0, '0);
    enq(32'hD000_0004, 32'h0000_0501, '0, 1'b0, '0);
    check_eq("prerst_count", 64'(ifc.count_o), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_valid", 64'(ifc.deq_valid_o), 64'd0);
    check_eq("rst2_count", 64'(ifc.count_o), 64'd0);
    check_eq("rst2_ready", 64'(ifc.enq_ready_o), 64'd1);
`ifdef IFQ_STATS_EN
    check_eq("rst2_full",  64'(stat_full_cycles), 64'd0);
    check_eq("rst2_drops", 64'(stat_flush_drops), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
